// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the FP MAC sequencer.
// States, default geometry and the exponent value that marks a zero operand.
package fp_mac_pkg;

    localparam int PIPE_DEPTH_DEF = 4;
    localparam int LEN_W_DEF      = 8;

    localparam logic [7:0] EXP_ZERO = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/fp_mac_vld_pipe.sv
// Valid-bit shadow of the MAC datapath: one bit per pipeline stage.
// Tail bit is the accumulator strobe; o_any flags anything still in flight.
module fp_mac_vld_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic i_clear,
    input  logic i_vld,
    output logic o_tail,
    output logic o_any
);

    logic [DEPTH-1:0] r_vld;

    always_ff @(posedge clock) begin
        if (i_clear) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    assign o_tail = r_vld[DEPTH-1];
    assign o_any  = |r_vld;

endmodule

// File: rtl/fp_mac_sequencer.sv
// Dot-product command sequencer for the FP MAC pipeline (enables only, no datapath).
// Build option FP_MAC_SEQ_SKIP_ZERO_EN: pairs with a zero exponent are consumed but not issued.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// ISSUE | streaming operand pairs into the multiplier
// DRAIN | all pairs consumed, waiting for in-flight products to retire
// DONE  | result valid, waiting for res_ready
module fp_mac_sequencer
    import fp_mac_pkg::*;
#(
    parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       op_a_ex,
    input  logic [7:0]       op_b_ex,
    output logic             issue,
    output logic             acc_clear,
    output logic             acc_en,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
    output logic [LEN_W-1:0] issued_cnt
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued_cnt;
    logic [LEN_W-1:0] r_retired_cnt;
    logic [LEN_W-1:0] w_issued_nxt;
    logic [LEN_W-1:0] w_retired_nxt;
    logic             r_acc_clear;
    logic             r_res_valid;
    logic             r_busy;
    logic             w_accept;
    logic             w_hs;
    logic             w_skip;
    logic             w_tail;
    logic             w_any;
    logic             w_drained;

`ifdef FP_MAC_SEQ_SKIP_ZERO_EN
    assign w_skip = (op_a_ex == EXP_ZERO) || (op_b_ex == EXP_ZERO);
`else
    logic w_unused_ex;
    assign w_unused_ex = ^{op_a_ex, op_b_ex};
    assign w_skip      = 1'b0;
`endif

    assign cmd_ready = resetn && (r_state == IDLE);
    assign op_ready  = resetn && (r_state == ISSUE) && (r_issued_cnt < r_len);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_hs      = op_valid && op_ready;
    assign issue     = w_hs && !w_skip;

    // Skipped pairs retire in the cycle they are consumed.
    assign w_issued_nxt  = r_issued_cnt + LEN_W'(w_hs);
    assign w_retired_nxt = r_retired_cnt + LEN_W'(w_tail) + LEN_W'(w_hs && w_skip);

    // Look one edge ahead so DONE follows the last strobe directly.
    assign w_drained = (w_retired_nxt == r_len) && (w_tail || !w_any);

    fp_mac_vld_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_vld_pipe (
        .clock   (clock),
        .i_clear (!resetn),
        .i_vld   (issue),
        .o_tail  (w_tail),
        .o_any   (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (cmd_len == '0) ? DRAIN : ISSUE;
            ISSUE:   if (w_issued_nxt == r_len) w_state_nxt = DRAIN;
            DRAIN:   if (w_drained) w_state_nxt = DONE;
            DONE:    if (res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_len         <= '0;
            r_issued_cnt  <= '0;
            r_retired_cnt <= '0;
            r_acc_clear   <= 1'b0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_acc_clear <= w_accept;
            r_res_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_len         <= cmd_len;
                r_issued_cnt  <= '0;
                r_retired_cnt <= '0;
            end else begin
                r_issued_cnt  <= w_issued_nxt;
                r_retired_cnt <= w_retired_nxt;
            end
        end
    end

    assign acc_clear  = r_acc_clear;
    assign acc_en     = w_tail;
    assign res_valid  = r_res_valid;
    assign busy       = r_busy;
    assign issued_cnt = r_issued_cnt;

endmodule

// File: tb/tb_fp_mac_sequencer.sv
// Scoreboard bench for fp_mac_sequencer: expected strobe cycles are queued at issue
// time and retired against acc_en; timing of clear/issue/result checked per command.
module tb_fp_mac_sequencer;

    localparam int PD = 4;
    localparam int LW = 8;
`ifdef FP_MAC_SEQ_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clock     = 1'b0;
    logic          resetn    = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [LW-1:0] cmd_len   = '0;
    logic          op_valid  = 1'b0;
    logic [7:0]    op_a_ex   = 8'h40;
    logic [7:0]    op_b_ex   = 8'h3f;
    logic          res_ready = 1'b0;
    logic          cmd_ready, op_ready, issue, acc_clear, acc_en, res_valid, busy;
    logic [LW-1:0] issued_cnt;

    int n_total   = 0;
    int n_bad     = 0;
    int cyc       = 0;
    int acc_total = 0;
    int iss_total = 0;
    int exp_q[$];

    fp_mac_sequencer #(
        .PIPE_DEPTH (PD),
        .LEN_W      (LW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_a_ex    (op_a_ex),
        .op_b_ex    (op_b_ex),
        .issue      (issue),
        .acc_clear  (acc_clear),
        .acc_en     (acc_en),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (acc_en === 1'b1) begin
            acc_total++;
            if (exp_q.size() == 0) check_val("acc_en_spurious", {31'd0, acc_en}, 32'd0);
            else check_val("acc_en_cycle", cyc, exp_q.pop_front());
        end
        if (issue === 1'b1) iss_total++;
    end

    // Called #1 after a rising edge with the DUT in IDLE; returns the same way.
    task automatic run_cmd(input int len, input bit gapped, input int zero_idx,
                           input int rr_hold, input int exp_iss);
        int t, c, n_hs, k, r, acc0, iss0;
        bit hs, zero;
        acc0 = acc_total;
        iss0 = iss_total;
        cmd_valid = 1'b1;
        cmd_len   = LW'(len);
        @(negedge clock);
        check_val("cmd_ready_idle", cmd_ready, 1);
        t = cyc;
        tick();
        cmd_valid = 1'b0;
        n_hs = 0;
        k    = t;
        c    = t + 1;
        while (n_hs < len) begin
            zero     = (n_hs == zero_idx);
            op_valid = gapped ? ((c - t) % 2 == 1) : 1'b1;
            op_a_ex  = zero ? 8'h00 : 8'h40;
            hs       = op_valid;
            @(negedge clock);
            if (c == t + 1) check_val("acc_clear_first", acc_clear, 1);
            check_val("op_ready_open", op_ready, 1);
            check_val("issue", issue, 32'(hs && !(SKIP && zero)));
            if (hs) begin
                if (!(SKIP && zero)) exp_q.push_back(c + PD);
                n_hs++;
                k = c;
            end
            tick();
            c++;
        end
        op_valid = 1'b1;
        op_a_ex  = 8'h40;
        @(negedge clock);
        check_val("op_ready_closed", op_ready, 0);
        check_val("issue_closed", issue, 0);
        check_val("acc_clear_once", acc_clear, 32'(len == 0));
        r = (len == 0) ? t + 2 : k + PD + 1;
        tick();
        op_valid = 1'b0;
        while (cyc < r) begin
            @(negedge clock);
            check_val("res_valid_early", res_valid, 0);
            tick();
        end
        res_ready = (rr_hold == 0);
        @(negedge clock);
        check_val("res_valid", res_valid, 1);
        check_val("issued_cnt", issued_cnt, len);
        check_val("busy_done", busy, 1);
        for (int i = 0; i < rr_hold; i++) begin
            tick();
            cmd_valid = 1'b1;
            cmd_len   = 8'd1;
            res_ready = (i == rr_hold - 1);
            @(negedge clock);
            check_val("res_valid_held", res_valid, 1);
            check_val("cmd_ready_done", cmd_ready, 0);
        end
        tick();
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        check_val("busy_idle", busy, 0);
        check_val("res_valid_drop", res_valid, 0);
        check_val("cmd_ready_back", cmd_ready, 1);
        check_val("acc_clear_none", acc_clear, 0);
        check_val("issue_count", iss_total - iss0, exp_iss);
        check_val("acc_en_count", acc_total - acc0, exp_iss);
        check_val("acc_en_missing", exp_q.size(), 0);
    endtask

    initial begin
        int t, acc0;
        resetn = 1'b0;
        repeat (3) tick();
        @(negedge clock);
        check_val("rst_cmd_ready", cmd_ready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_acc_clear", acc_clear, 0);
        check_val("rst_acc_en", acc_en, 0);
        check_val("rst_issued_cnt", issued_cnt, 0);
        tick();
        resetn = 1'b1;
        @(negedge clock);
        check_val("idle_cmd_ready", cmd_ready, 1);
        check_val("idle_op_ready", op_ready, 0);
        tick();

        run_cmd(3, 1'b0, -1, 0, 3);
        run_cmd(0, 1'b0, -1, 0, 0);
        run_cmd(4, 1'b1, -1, 0, 4);
        run_cmd(2, 1'b0, -1, 5, 2);
        run_cmd(1, 1'b0, -1, 0, 1);
        run_cmd(4, 1'b0, 1, 0, SKIP ? 3 : 4);

        // Reset in DRAIN with two products still in the pipe.
        cmd_valid = 1'b1;
        cmd_len   = 8'd4;
        @(negedge clock);
        check_val("mid_cmd_ready", cmd_ready, 1);
        t = cyc;
        tick();
        cmd_valid = 1'b0;
        op_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(t + i + PD);
            tick();
        end
        op_valid = 1'b0;
        tick();
        resetn = 1'b0;
        @(negedge clock);
        check_val("mid_busy", busy, 1);
        check_val("mid_issued_cnt", issued_cnt, 4);
        tick();
        exp_q.delete();
        acc0 = acc_total;
        @(negedge clock);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_issued_cnt", issued_cnt, 0);
        check_val("mid_rst_acc_en", acc_en, 0);
        check_val("mid_rst_cmd_ready", cmd_ready, 0);
        tick();
        resetn = 1'b1;
        @(negedge clock);
        check_val("mid_idle_cmd_ready", cmd_ready, 1);
        repeat (4) tick();
        check_val("mid_no_acc_en", acc_total - acc0, 0);

        run_cmd(2, 1'b0, -1, 0, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
